// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch next-PC control slice: mux selects, opcodes,
// and the 2-bit branch history counter type with its saturating update.
package fetch_pkg;

  localparam logic [2:0] PC_SEL_NEXT       = 3'd0;
  localparam logic [2:0] PC_SEL_BR_RESOLVE = 3'd1;
  localparam logic [2:0] PC_SEL_JUMP_X     = 3'd2;
  localparam logic [2:0] PC_SEL_BR_PREDICT = 3'd3;
  localparam logic [2:0] PC_SEL_JAL        = 3'd4;
  localparam logic [2:0] PC_SEL_JALR       = 3'd5;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_INIT = 2'b01;

  function automatic bht_ctr_t bht_sat_update(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    res = ctr;
    if (taken && ctr != 2'b11)
      res = ctr + 2'b01;
    else if (!taken && ctr != 2'b00)
      res = ctr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: array of 2-bit saturating counters with a combinational
// read port (no write bypass) and one synchronous update port.
module fetch_bht
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_ctr_t         rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  bht_ctr_t ctr_q [ENTRIES];
  bht_ctr_t upd_ctr_d;

  assign rd_ctr_o  = ctr_q[rd_idx_i];
  assign upd_ctr_d = bht_sat_update(ctr_q[upd_idx_i], upd_taken_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= BHT_INIT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= upd_ctr_d;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch next-PC select control with BHT prediction, mispredict/JALR flush, and
// optional resolved-branch statistics enabled by FETCH_PC_CTRL_STATS_EN.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        bp_enable,
  input  logic        fd_valid,
  input  logic [6:0]  fd_opcode,
  input  logic [31:0] fd_pc,
  input  logic        x_valid,
  input  logic        x_is_branch,
  input  logic        x_is_jalr,
  input  logic        x_br_taken,
  output logic [2:0]  pc_sel,
  output logic        br_pred_taken,
  output logic        flush_fd,
  output logic        mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_x_q;
  logic             pred_x_q;
  logic             x_tracked_q;
  bht_ctr_t         rd_ctr;
  logic             fd_is_br;
  logic             fd_is_jal;
  logic             pred_raw;
  logic             misp_raw;
  logic             bht_upd;
  logic             unused_pc;

  assign idx       = fd_pc[IDX_LSB +: IDX_W];
  assign unused_pc = ^fd_pc;
  assign fd_is_br  = fd_valid && (fd_opcode == OPC_BRANCH);
  assign fd_is_jal = fd_valid && (fd_opcode == OPC_JAL);
  assign pred_raw  = bp_enable && fd_is_br && rd_ctr[1];
  assign bht_upd   = x_valid && x_is_branch && !stall;

  // pred_x is only ever set for a tracked branch, so the AND is a no-op guard.
  always_comb begin
    if (bp_enable)
      misp_raw = x_valid && x_is_branch && (x_br_taken != (pred_x_q && x_tracked_q));
    else
      misp_raw = x_valid && x_is_branch && x_br_taken;
  end

  always_comb begin
    pc_sel        = PC_SEL_NEXT;
    flush_fd      = 1'b0;
    br_pred_taken = 1'b0;
    mispredict    = 1'b0;
    if (!rst) begin
      br_pred_taken = pred_raw;
      mispredict    = misp_raw;
      if (!stall) begin
        if (x_valid && x_is_jalr) begin
          pc_sel   = PC_SEL_JUMP_X;
          flush_fd = 1'b1;
        end else if (misp_raw) begin
          pc_sel   = PC_SEL_BR_RESOLVE;
          flush_fd = 1'b1;
        end else if (fd_is_br) begin
          pc_sel = PC_SEL_BR_PREDICT;
        end else if (fd_is_jal) begin
          pc_sel = PC_SEL_JAL;
        end
      end
    end
  end

  fetch_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (idx),
    .rd_ctr_o    (rd_ctr),
    .upd_en_i    (bht_upd),
    .upd_idx_i   (idx_x_q),
    .upd_taken_i (x_br_taken)
  );

  // F/D -> X stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_x_q    <= 1'b0;
      idx_x_q     <= '0;
      x_tracked_q <= 1'b0;
    end else if (!stall) begin
      if (flush_fd) begin
        pred_x_q    <= 1'b0;
        x_tracked_q <= 1'b0;
      end else begin
        pred_x_q    <= pred_raw;
        idx_x_q     <= idx;
        x_tracked_q <= fd_is_br;
      end
    end
  end

`ifdef FETCH_PC_CTRL_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (bht_upd)
        stat_br_q <= stat_br_q + 32'd1;
      if (misp_raw && !stall)
        stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: each step drives one cycle of inputs, queues
// the expected outputs, and checks them at the falling edge.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        bp_enable = 1'b0;
  logic        fd_valid = 1'b0;
  logic [6:0]  fd_opcode = 7'd0;
  logic [31:0] fd_pc = 32'h4000_0010;
  logic        x_valid = 1'b0;
  logic        x_is_branch = 1'b0;
  logic        x_is_jalr = 1'b0;
  logic        x_br_taken = 1'b0;
  logic [2:0]  pc_sel;
  logic        br_pred_taken;
  logic        flush_fd;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

`ifdef FETCH_PC_CTRL_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  typedef struct {
    string       tag;
    logic [2:0]  sel;
    logic        pred;
    logic        flush;
    logic        misp;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cnt_br = 0;
  int   cnt_mp = 0;

  fetch_pc_ctrl #(.BHT_ENTRIES(64), .IDX_LSB(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .bp_enable        (bp_enable),
    .fd_valid         (fd_valid),
    .fd_opcode        (fd_opcode),
    .fd_pc            (fd_pc),
    .x_valid          (x_valid),
    .x_is_branch      (x_is_branch),
    .x_is_jalr        (x_is_jalr),
    .x_br_taken       (x_br_taken),
    .pc_sel           (pc_sel),
    .br_pred_taken    (br_pred_taken),
    .flush_fd         (flush_fd),
    .mispredict       (mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
    end
  endtask

  // One cycle: drive, queue expectation, compare at negedge, advance past posedge.
  task automatic step(input string tag, input bit st, input bit bp, input bit fdv,
                      input logic [6:0] opc, input bit xv, input bit xb, input bit xj,
                      input bit xt, input logic [2:0] e_sel, input bit e_pred,
                      input bit e_flush, input bit e_misp);
    exp_t e;
    exp_t got;
    stall       = st;
    bp_enable   = bp;
    fd_valid    = fdv;
    fd_opcode   = opc;
    x_valid     = xv;
    x_is_branch = xb;
    x_is_jalr   = xj;
    x_br_taken  = xt;
    e.tag   = tag;
    e.sel   = e_sel;
    e.pred  = e_pred;
    e.flush = e_flush;
    e.misp  = e_misp;
    e.sb    = STATS_ON ? cnt_br : 0;
    e.sm    = STATS_ON ? cnt_mp : 0;
    exp_q.push_back(e);
    if (rst) begin
      cnt_br = 0;
      cnt_mp = 0;
    end else if (!st) begin
      if (xv && xb) cnt_br++;
      if (e_misp)   cnt_mp++;
    end
    @(negedge clk);
    got = exp_q.pop_front();
    chk(got.tag, "pc_sel", {29'd0, pc_sel}, {29'd0, got.sel});
    chk(got.tag, "br_pred_taken", {31'd0, br_pred_taken}, {31'd0, got.pred});
    chk(got.tag, "flush_fd", {31'd0, flush_fd}, {31'd0, got.flush});
    chk(got.tag, "mispredict", {31'd0, mispredict}, {31'd0, got.misp});
    chk(got.tag, "stat_branches", stat_branches, got.sb);
    chk(got.tag, "stat_mispredicts", stat_mispredicts, got.sm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    //            tag          st bp fdv opc xv xb xj xt  sel  pred fl misp
    step("reset",       0, 0, 0, 7'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    rst = 1'b0;
    step("first_br",    0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 0, 0, 0);
    step("tk1_misp",    0, 1, 0, 7'd0, 1, 1, 0, 1, 3'd1, 0, 1, 1);
    step("pred_10",     0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 1, 0, 0);
    step("tk2_ok",      0, 1, 0, 7'd0, 1, 1, 0, 1, 3'd0, 0, 0, 0);
    step("pred_11",     0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 1, 0, 0);
    step("sat_tk3",     0, 1, 1, BR,   1, 1, 0, 1, 3'd3, 1, 0, 0);
    step("sat_tk4",     0, 1, 1, BR,   1, 1, 0, 1, 3'd3, 1, 0, 0);
    step("sat_hold",    0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 1, 0, 0);
    step("nt_misp",     0, 1, 1, BR,   1, 1, 0, 0, 3'd1, 1, 1, 1);
    step("after_flush", 0, 1, 0, 7'd0, 1, 1, 0, 0, 3'd0, 0, 0, 0);
    step("dec_01",      0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 0, 0, 0);
    step("jalr_vs_jal", 0, 1, 1, JAL,  1, 0, 1, 0, 3'd2, 0, 1, 0);
    step("jal",         0, 1, 1, JAL,  0, 0, 0, 0, 3'd4, 0, 0, 0);
    step("stall1",      1, 1, 1, BR,   1, 1, 0, 1, 3'd0, 0, 0, 1);
    step("stall2",      1, 1, 1, BR,   1, 1, 0, 1, 3'd0, 0, 0, 1);
    step("unstall",     0, 1, 0, 7'd0, 1, 1, 0, 1, 3'd1, 0, 1, 1);
    step("once_10",     0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 1, 0, 0);
    step("nt_from_10",  0, 1, 0, 7'd0, 1, 1, 0, 0, 3'd1, 0, 1, 1);
    step("once_01",     0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 0, 0, 0);
    step("bpoff_fd",    0, 0, 1, BR,   0, 0, 0, 0, 3'd3, 0, 0, 0);
    step("bpoff_tk",    0, 0, 0, 7'd0, 1, 1, 0, 1, 3'd1, 0, 1, 1);
    step("bpon_trained",0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 1, 0, 0);
    fd_pc = 32'h4000_0014;
    step("other_idx",   0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 0, 0, 0);
    fd_pc = 32'h4000_0010;
    rst = 1'b1;
    step("mid_rst",     0, 1, 1, BR,   1, 1, 0, 1, 3'd0, 0, 0, 0);
    rst = 1'b0;
    step("post_rst",    0, 1, 1, BR,   0, 0, 0, 0, 3'd3, 0, 0, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
